sec_ded_locator_seq: RTL
========================

Name: sec_ded_locator_seq

Overview:
Parametrised, clocked Hamming SEC-DED decoder. It locates a single-bit error with a sequential position scan, scanning LANES positions per cycle, instead of a full combinational decoder. It takes one codeword per valid/ready transaction and returns the corrected data word with status flags. It succeeds the fixed-width clocked location decoders and adds three things they lack: double-error detection, in/out handshakes and a width/throughput trade-off.

Parameters:
K, 30, data bits per codeword
R, 6, Hamming check bits; must satisfy 2^R >= K+R+1
LANES, 1, positions compared per SCAN cycle (1..N)
N (localparam), K+R+1, codeword width including overall parity bit
PW (localparam), $clog2(N), width of position/syndrome index

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cw_in  in  N  codeword; bit 0 = overall parity, bit 2^j = check bit j, other positions = data ascending
in_valid  in  1  cw_in valid
in_ready  out  1  block can accept a codeword
data_out  out  K  corrected data (data positions ascending, from bit 3 upward)
err_pos  out  PW  corrected bit position (valid when err_corrected)
err_corrected  out  1  single error found and flipped
err_uncorrectable  out  1  double error or out-of-range syndrome
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, err_pos=0, both flags=0, scan index=0.
- IDLE: in_ready=1. On in_valid&in_ready, latch cw_in and go to SYND.
- SYND (1 cycle): compute s = XOR of indices p (1..N-1) where cw[p]=1, and P = XOR of all N bits. Decision:
  - s=0, P=0: no error -> DONE.
  - P=0, s!=0: double error -> DONE, err_uncorrectable=1.
  - P=1, s>=N: uncorrectable -> DONE.
  - P=1, s<N: -> SCAN, idx=0.
- SCAN: compare positions idx..idx+LANES-1 (those < N) against s. On match, flip that bit in the latched word, set err_pos=s and err_corrected=1, go to DONE. Otherwise idx += LANES. If idx >= N with no match, set err_uncorrectable and go to DONE (guard only).
- s=0 with P=1 means the error is in the parity bit. It matches in the first SCAN cycle: err_pos=0, data unchanged.
- DONE: out_valid=1. data_out, err_pos and flags stay stable until out_ready=1. On the handshake edge, go to IDLE and clear out_valid.
- On uncorrectable results, data_out carries the raw data bits unmodified.
- in_ready=0 in SYND, SCAN and DONE. There is no overlap: one codeword in flight.
- Latency, counted in rising edges from the accepting edge to out_valid high:
  - no-error / uncorrectable: 2
  - single error at s: 3 + floor(s/LANES)
  - For N=37, LANES=1, worst case is 39.
- Flags are mutually exclusive and are cleared when a new codeword is accepted.
- Reset mid-operation: the latched word and outputs are discarded immediately; the block returns to the reset state. No partial result is emitted.
- If out_ready is already high when DONE is entered, out_valid is high for exactly one cycle.

Decomposition:
- Shared package sec_pkg holds:
  - the state enum (IDLE, SYND, SCAN, DONE)
  - function is_pow2(p)
  - function data_index(p) mapping codeword position to data bit
  - function syndrome(cw) as a constant-width XOR reduction
  - the encoder helper used by the bench
- One natural sub-module: sec_syndrome_calc. It is combinational, producing s and P from a latched N-bit word, and is reusable by a future encoder check.

Test Plan:
- Clean all-zero codeword, out_ready=1 -> data_out=0, no flags, out_valid 2 edges after accept.
- Encoded data 30'h3FFFFFFF (all ones) with bit 5 flipped, LANES=1 -> data_out=30'h3FFFFFFF, err_corrected=1, err_pos=5, latency 8.
- Zero codeword with bits 3 and 6 flipped -> err_uncorrectable=1, err_corrected=0, data_out=raw data, latency 2. Separately, only bit 0 flipped -> err_corrected=1, err_pos=0, latency 3.
- Bit 36 flipped, LANES=4 -> err_pos=36, latency 3+9=12. Repeat with LANES=1 -> latency 39.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is not accepted. Release -> one handshake, then IDLE.
- Assert rst_n=0 for half a cycle during SCAN -> all outputs 0 immediately and in_ready=1. The next clean codeword decodes normally.

Source files
------------

// File: rtl/sec_ded_locator_seq_pkg.sv
// Shared types and helpers for the sequential SEC-DED locator and its bench.
package sec_pkg;

  // Widest codeword the helpers support; callers zero-extend narrower words.
  localparam int unsigned MaxN  = 128;
  localparam int unsigned MaxPw = 7;

  typedef enum logic [1:0] {
    StIdle,
    StSynd,
    StScan,
    StDone
  } state_e;

  function automatic logic is_pow2(int unsigned p);
    return (p != 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data bit carried at codeword position p (p must be a non-power-of-two >= 3).
  function automatic int unsigned data_index(int unsigned p);
    int unsigned c;
    c = 0;
    for (int unsigned q = 3; q < MaxN; q++) begin
      if (q < p && !is_pow2(q)) c++;
    end
    return c;
  endfunction

  // XOR of the indices of all set bits, excluding the overall parity bit.
  function automatic logic [MaxPw-1:0] syndrome(logic [MaxN-1:0] cw);
    logic [MaxPw-1:0] s;
    s = '0;
    for (int p = 1; p < MaxN; p++) begin
      if (cw[p]) s ^= p[MaxPw-1:0];
    end
    return s;
  endfunction

  // Builds an extended Hamming codeword from k data bits with r check bits.
  function automatic logic [MaxN-1:0] encode(logic [MaxN-1:0] data, int unsigned k,
                                             int unsigned r);
    logic [MaxN-1:0]  cw;
    logic [MaxPw-1:0] s;
    int unsigned      d;
    cw = '0;
    d  = 0;
    for (int unsigned p = 3; p < MaxN; p++) begin
      if (!is_pow2(p) && d < k) begin
        cw[p] = data[d];
        d++;
      end
    end
    s = syndrome(cw);
    for (int unsigned j = 0; j < MaxPw; j++) begin
      if (j < r) cw[1 << j] = s[j];
    end
    cw[0] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/sec_ded_locator_seq_if.sv
// Codeword-in / result-out handshake bundle for the SEC-DED locator.
interface sec_ded_locator_seq_if #(
  parameter int unsigned K = 30,
  parameter int unsigned R = 6
);
  localparam int unsigned N  = K + R + 1;
  localparam int unsigned PW = $clog2(N);

  logic [N-1:0]  cw_in;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  data_out;
  logic [PW-1:0] err_pos;
  logic          err_corrected;
  logic          err_uncorrectable;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output cw_in, in_valid, out_ready,
    input  in_ready, data_out, err_pos, err_corrected, err_uncorrectable, out_valid
  );

  modport slave (
    input  cw_in, in_valid, out_ready,
    output in_ready, data_out, err_pos, err_corrected, err_uncorrectable, out_valid
  );
endinterface

// File: rtl/sec_ded_locator_seq_syndrome_calc.sv
// Combinational syndrome and overall parity of a latched codeword.
module sec_syndrome_calc #(
  parameter int unsigned N  = 37,
  parameter int unsigned PW = 6
) (
  input  logic [N-1:0]  word,
  output logic [PW-1:0] synd,
  output logic          parity
);

  // Indices below N fit in PW bits, so their XOR does too.
  always_comb begin
    synd = '0;
    for (int p = 1; p < N; p++) begin
      if (word[p]) synd ^= p[PW-1:0];
    end
    parity = ^word;
  end

endmodule

// File: rtl/sec_ded_locator_seq.sv
// Clocked SEC-DED decoder: one-cycle syndrome, then a LANES-wide position scan.
module sec_ded_locator_seq
  import sec_pkg::*;
#(
  parameter int unsigned K     = 30,
  parameter int unsigned R     = 6,
  parameter int unsigned LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sec_ded_locator_seq_if.slave   bus,
  output logic                   busy
);

  localparam int unsigned N  = K + R + 1;
  localparam int unsigned PW = $clog2(N);
  // Scan index may overshoot N by up to LANES before the guard fires.
  localparam int unsigned IW = $clog2(N + LANES + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  word_q, word_d;
  logic [PW-1:0] synd_q, synd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] err_pos_q, err_pos_d;
  logic          corr_q, corr_d;
  logic          unc_q, unc_d;

  logic [PW-1:0] synd;
  logic          parity;

  sec_syndrome_calc #(
    .N  (N),
    .PW (PW)
  ) u_synd (
    .word   (word_q),
    .synd   (synd),
    .parity (parity)
  );

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      word_q    <= '0;
      synd_q    <= '0;
      idx_q     <= '0;
      err_pos_q <= '0;
      corr_q    <= 1'b0;
      unc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      synd_q    <= synd_d;
      idx_q     <= idx_d;
      err_pos_q <= err_pos_d;
      corr_q    <= corr_d;
      unc_q     <= unc_d;
    end
  end

  // Next-state: accept, classify by syndrome/parity, scan for the flipped bit.
  always_comb begin
    logic        found;
    logic [31:0] pos;
    state_d   = state_q;
    word_d    = word_q;
    synd_d    = synd_q;
    idx_d     = idx_q;
    err_pos_d = err_pos_q;
    corr_d    = corr_q;
    unc_d     = unc_q;
    found     = 1'b0;
    pos       = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          word_d    = bus.cw_in;
          synd_d    = '0;
          idx_d     = '0;
          err_pos_d = '0;
          corr_d    = 1'b0;
          unc_d     = 1'b0;
          state_d   = StSynd;
        end
      end
      StSynd: begin
        synd_d = synd;
        idx_d  = '0;
        if (!parity) begin
          unc_d   = (synd != '0);
          state_d = StDone;
        end else if (32'(synd) >= N) begin
          unc_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StScan;
        end
      end
      StScan: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          pos = 32'(idx_q) + l;
          if (!found && pos < N && pos == 32'(synd_q)) begin
            found       = 1'b1;
            word_d[pos] = ~word_q[pos];
            err_pos_d   = synd_q;
            corr_d      = 1'b1;
            state_d     = StDone;
          end
        end
        if (!found) begin
          idx_d = idx_q + IW'(LANES);
          // Unreachable for an in-range syndrome; keeps the scan bounded.
          if (32'(idx_q) + LANES >= N) begin
            unc_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Unpack data positions (non-powers-of-two from 3 upward) into the result word.
  always_comb begin
    bus.data_out = '0;
    for (int unsigned p = 3; p < N; p++) begin
      if (!is_pow2(p)) bus.data_out[data_index(p)] = word_q[p];
    end
  end

  // Handshake and status outputs.
  always_comb begin
    bus.in_ready          = (state_q == StIdle);
    bus.out_valid         = (state_q == StDone);
    bus.err_pos           = err_pos_q;
    bus.err_corrected     = corr_q;
    bus.err_uncorrectable = unc_q;
    busy                  = (state_q != StIdle);
  end

endmodule
